// File: rtl/sram_1rw1r_model.sv
// Behavioural 1RW + 1R SRAM: byte write masks, READ_LATENCY-deep read pipeline with
// valid strobes, sticky out-of-range flag. Define SRAM_RW_BYPASS_EN for write-through on collisions.

module sram_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          rd_vld,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] dout,
  output logic          dvalid
);
  // Stage 0 captures the array at the accepting edge; stage LAT drives the port.
  logic [LAT:0]         vld_pipe;
  logic [LAT:0][DW-1:0] dat_pipe;

  // Data stages load only behind a valid, so the output stage holds the last read.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], rd_vld};
      if (rd_vld) dat_pipe[0] <= rd_data;
      for (int k = 1; k <= LAT; k++)
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
    end
  end

  assign dout   = dat_pipe[LAT];
  assign dvalid = vld_pipe[LAT];
endmodule

module sram_1rw1r_model #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int NUM_WORDS    = 2048,
  parameter int READ_LATENCY = 1,
  parameter int NUM_WMASKS   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  output logic                  oor_err
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = NUM_WORDS[ADDR_WIDTH:0];

  typedef struct packed {
    logic             rd;
    logic             xin;
    logic             in_rng;
    logic [IDX_W-1:0] idx;
  } acc_t;

  logic [DATA_WIDTH-1:0]      mem [NUM_WORDS];
  acc_t                       acc0, acc1;
  logic                       wr0;
  logic [NUM_WMASKS-1:0][7:0] old0, new0;
  logic [1:0]                 rd_vld, pipe_dvalid;
  logic [1:0][DATA_WIDTH-1:0] rd_data, pipe_dout;

  // An unknown control strobe poisons the access rather than guessing read vs write.
  always_comb begin
    acc0.xin    = $isunknown({csb0, web0});
    acc0.rd     = !csb0 && web0;
    acc0.in_rng = {1'b0, addr0} < DEPTH;
    acc0.idx    = addr0[IDX_W-1:0];
    wr0         = !csb0 && !web0;
    acc1.xin    = $isunknown(csb1);
    acc1.rd     = !csb1;
    acc1.in_rng = {1'b0, addr1} < DEPTH;
    acc1.idx    = addr1[IDX_W-1:0];
  end

  assign old0 = mem[acc0.idx];

  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
    assign new0[i] = wmask0[i] ? din0[8*i +: 8] : old0[i];
  end

`ifdef SRAM_RW_BYPASS_EN
  logic coll;
  assign coll = wr0 && acc1.rd && acc0.in_rng && (addr0 == addr1);
`endif

  always_comb begin
    rd_data = '0;
    if (acc0.xin)        rd_data[0] = 'x;
    else if (acc0.in_rng) rd_data[0] = old0;
    if (acc1.xin) rd_data[1] = 'x;
    else if (acc1.in_rng) begin
`ifdef SRAM_RW_BYPASS_EN
      rd_data[1] = coll ? new0 : mem[acc1.idx];
`else
      rd_data[1] = mem[acc1.idx];
`endif
    end
  end

  assign rd_vld = {acc1.rd | acc1.xin, acc0.rd | acc0.xin};

  // Array is never cleared; the reset term only blocks writes while rstb is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (rstb) begin
      if (acc0.xin) begin
        if (!$isunknown(addr0) && acc0.in_rng) mem[acc0.idx] <= 'x;
      end else if (wr0 && acc0.in_rng) begin
        mem[acc0.idx] <= new0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      oor_err <= 1'b0;
    else if ((!csb0 && !acc0.in_rng) || (acc1.rd && !acc1.in_rng))
      oor_err <= 1'b1;
  end

  sram_rd_pipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_rd_pipe [1:0] (
    .clk    (clk),
    .rstb   (rstb),
    .rd_vld (rd_vld),
    .rd_data(rd_data),
    .dout   (pipe_dout),
    .dvalid (pipe_dvalid)
  );

  assign dout0   = pipe_dout[0];
  assign dvalid0 = pipe_dvalid[0];
  assign dout1   = pipe_dout[1];
  assign dvalid1 = pipe_dvalid[1];
endmodule

// File: doc/sram_1rw1r_model.md
Name: sram_1rw1r_model

Overview:
- Parametrised behavioural SRAM model with two ports: port 0 read/write, port 1 read-only.
- Adds byte write masks, separate data-in/data-out buses, and a configurable read-latency pipeline with valid strobes.
- Adds an asynchronous active-low reset for output/pipeline state, and defined read-during-write and out-of-range behaviour.
- Used as the simulation model behind generated multi-port macros and as a drop-in for testbenches of larger cores.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, address bus width.
- NUM_WORDS, 2048, implemented depth; must be at most 2^ADDR_WIDTH.
- READ_LATENCY, 1, clocks from read-accepting edge to dout valid; legal range 1..4.
- NUM_WMASKS, DATA_WIDTH/8, byte-lane count (derived).

Ports:
- clk  input  1  clock; all sampling on rising edge.
- rstb  input  1  asynchronous active-low reset.
- csb0  input  1  port 0 chip select, active low.
- web0  input  1  port 0 write enable, active low.
- wmask0  input  NUM_WMASKS  port 0 byte write mask, 1 = lane written.
- addr0  input  ADDR_WIDTH  port 0 address.
- din0  input  DATA_WIDTH  port 0 write data.
- dout0  output  DATA_WIDTH  port 0 read data.
- dvalid0  output  1  port 0 read-data valid, one-cycle pulse per read.
- csb1  input  1  port 1 chip select, active low.
- addr1  input  ADDR_WIDTH  port 1 address.
- dout1  output  DATA_WIDTH  port 1 read data.
- dvalid1  output  1  port 1 read-data valid.
- oor_err  output  1  sticky flag: an access was issued with an address >= NUM_WORDS.

Behaviour:
- Clock `clk`; reset `rstb`, asynchronous, active-low.
- While rstb = 0:
  - dout0, dout1 = 0; dvalid0, dvalid1 = 0; oor_err = 0.
  - All read pipeline stages flushed.
  - Memory array contents retained, not cleared.
  - No writes occur.
- Reset asserted mid-read: in-flight reads are discarded and no dvalid is produced for them.
- First edge after rstb rises: accesses are accepted normally.
- Port 0 write (csb0 = 0, web0 = 0):
  - At the edge, for each lane i with wmask0[i] = 1, mem[addr0][8i+7:8i] takes din0[8i+7:8i].
  - Unmasked lanes are unchanged. wmask0 = 0 is a legal no-op.
  - No dvalid0 pulse; dout0 holds its last value.
- Port 0 read (csb0 = 0, web0 = 1):
  - mem[addr0] is sampled at the edge.
  - The value appears on dout0 with dvalid0 = 1 exactly READ_LATENCY edges later.
  - dvalid0 is high for one cycle per read.
- Port 1 read (csb1 = 0): same as a port 0 read, using addr1, dout1, dvalid1.
- Pipeline:
  - READ_LATENCY-deep shift of {valid, data} per port; back-to-back reads every cycle are supported.
  - dout holds the last valid data when no read completes.
- Idle (csb = 1): no array access; a 0 enters the valid pipeline.
- Out-of-range (addr >= NUM_WORDS, csb = 0):
  - Write is ignored.
  - Read returns all-zero data with dvalid asserted on schedule.
  - oor_err is set and stays set until reset.
- Read-during-write collision: same address, port 0 writing and port 1 reading at the same edge. Result per the Optional Feature.
- Port 0 cannot read and write at the same edge, so no self-collision exists.
- Unknown (X/Z) on csb or web at a clock edge: the model writes all-X to the addressed word (if addr is known) and produces X on the data out.

Optional Feature:
- Macro: SRAM_RW_BYPASS_EN.
- Defined: on a collision, dout1 returns the newly written word (old data in unmasked lanes, din0 in masked lanes).
- Undefined (default): dout1 returns the pre-write contents of the word. The write still completes.

Test Plan:
- Reset/latency, READ_LATENCY = 2:
  - Reset, write 0xDEADBEEF to addr 5 with wmask0 = 0xF, then read port 1 addr 5.
  - Required: dvalid1 high exactly 2 edges after the read edge, dout1 = 0xDEADBEEF.
  - Required: outputs are 0 during reset.
- Byte mask:
  - Write 0x11223344 to addr 7 (mask 0xF), then 0xAABBCCDD with mask 0x5, then read port 0.
  - Required: 0x11BB33DD.
- Back-to-back reads: read addresses 0, 1, 2 on consecutive cycles from preloaded 0xA0, 0xA1, 0xA2.
  - Required: three consecutive dvalid1 pulses with data in order.
- Collision: addr 9 holds 0x0; port 0 writes 0xFFFFFFFF while port 1 reads addr 9 at the same edge.
  - Required: dout1 = 0x0 without SRAM_RW_BYPASS_EN, 0xFFFFFFFF with it.
  - Required (either case): a subsequent read returns 0xFFFFFFFF.
- Out-of-range: NUM_WORDS = 1000; write 0x12345678 to addr 1500, then read addr 1500.
  - Required: dout = 0, dvalid pulses, oor_err = 1 and remains 1 until rstb is pulsed.
- Reset mid-read: READ_LATENCY = 3; issue a read, assert rstb low one cycle later.
  - Required: no dvalid pulse.
  - Required: after release, memory contents are intact (read returns the prior value).
